// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM state, FIFO depth and word width for the fetch unit
package ifetch_pkg;
    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W      = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {RUN, FULL, DRAIN} state_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: shift-style {pc, inst} buffer whose head is always entry 0
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_inst,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_inst,
    output logic [CNT_W-1:0] o_count
);
    logic [XLEN-1:0]  r_pc   [FIFO_DEPTH];
    logic [XLEN-1:0]  r_inst [FIFO_DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;
    logic [IDX_W-1:0] w_wr;
    assign w_pop   = i_pop && r_count != '0;
    assign w_push  = i_push && (r_count != CNT_W'(FIFO_DEPTH) || w_pop);
    assign w_wr    = IDX_W'(r_count - CNT_W'(w_pop));
    assign o_valid = r_count != '0;
    assign o_pc    = r_pc[0];
    assign o_inst  = r_inst[0];
    assign o_count = r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_pc[k]   <= '0;
                r_inst[k] <= '0;
            end
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            if (w_pop)
                for (int k = 0; k < FIFO_DEPTH - 1; k++) begin
                    r_pc[k]   <= r_pc[k+1];
                    r_inst[k] <= r_inst[k+1];
                end
            if (w_push) begin
                r_pc[w_wr]   <= i_pc;
                r_inst[w_wr] <= i_inst;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch with redirect/drain FSM; IFETCH_PERF_EN adds perf_bubble counter
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] npc,
    input  logic            npc_load,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_bubble
`endif
);
    state_t           r_state;
    state_t           w_next;
    logic [XLEN-1:0]  r_fpc;
    logic [XLEN-1:0]  r_daddr;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_count;
    assign w_pop     = inst_valid && inst_ready;
    assign w_push    = r_state == RUN && imem_ack && !npc_load;
    assign imem_req  = rst_n && r_state != FULL;
    assign imem_addr = r_state == DRAIN ? r_daddr : r_fpc;
    // a redirect without ack leaves a request in flight, so DRAIN keeps presenting the old address
    always_comb begin
        w_next = r_state == RUN  ? (npc_load ? (imem_ack ? RUN : DRAIN) :
                                    (w_push && !w_pop && w_count == CNT_W'(FIFO_DEPTH - 1)) ? FULL : RUN) :
                 r_state == FULL ? ((npc_load || w_pop) ? RUN : FULL) :
                                   (imem_ack ? RUN : DRAIN);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_fpc   <= RESET_PC;
            r_daddr <= RESET_PC;
        end else begin
            r_state <= w_next;
            r_fpc   <= npc_load ? npc : w_push ? r_fpc + 32'd1 : r_fpc;
            if (r_state != DRAIN)
                r_daddr <= r_fpc;
        end
    end
    ifetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (npc_load),
        .i_pc    (r_fpc),
        .i_inst  (imem_rdata),
        .o_valid (inst_valid),
        .o_pc    (inst_pc),
        .o_inst  (inst),
        .o_count (w_count)
    );
`ifdef IFETCH_PERF_EN
    logic [XLEN-1:0] r_bubble;
    assign perf_bubble = r_bubble;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bubble <= '0;
        else if (!inst_valid && r_bubble != '1)
            r_bubble <= r_bubble + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and random checks of ifetch_unit against a queue-based fetch model
module tb_ifetch_unit;
    localparam logic [31:0] RPC = 32'h100;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        npc_load = 1'b0;
    logic        imem_ack = 1'b0;
    logic        inst_ready = 1'b0;
    logic [31:0] npc = 32'h0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        imem_req;
    logic        inst_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_bubble;
    logic [31:0] m_bub;
`endif
    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_daddr;
    bit          m_drain;
    bit          m_stall;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = imem_ack ? mem(imem_addr) : 32'hDEAD_BEEF;

    ifetch_unit #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .npc_load   (npc_load),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_bubble(perf_bubble)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Fetch model: queue holds PCs of buffered instructions; data is mem(pc)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_fpc   = RPC;
            m_daddr = RPC;
            m_drain = 0;
            m_stall = 0;
`ifdef IFETCH_PERF_EN
            m_bub   = 0;
`endif
        end else begin
            bit pop;
            pop = q.size() != 0 && inst_ready;
`ifdef IFETCH_PERF_EN
            if (q.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub++;
`endif
            if (m_stall) begin
                if (npc_load) begin
                    q.delete();
                    m_fpc   = npc;
                    m_stall = 0;
                end else if (pop) begin
                    void'(q.pop_front());
                    m_stall = 0;
                end
            end else if (m_drain) begin
                if (npc_load) m_fpc = npc;
                if (imem_ack) m_drain = 0;
            end else if (npc_load) begin
                q.delete();
                m_daddr = m_fpc;
                m_fpc   = npc;
                m_drain = !imem_ack;
            end else begin
                if (pop) void'(q.pop_front());
                if (imem_ack) begin
                    q.push_back(m_fpc);
                    m_fpc++;
                end
                m_stall = q.size() == 2;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, rst_n && !m_stall});
        if (rst_n && !m_stall) chk("imem_addr", imem_addr, m_drain ? m_daddr : m_fpc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0]);
            chk("inst", inst, mem(q[0]));
        end else if (!rst_n) begin
            chk("rst_inst_pc", inst_pc, 32'h0);
            chk("rst_inst", inst, 32'h0);
        end
`ifdef IFETCH_PERF_EN
        chk("perf_bubble", perf_bubble, m_bub);
`endif
    end

    initial begin
        repeat (3) cyc();
        chk("lit_rst_req", {31'b0, imem_req}, 32'h0);
        chk("lit_rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("lit_rst_pc", inst_pc, 32'h0);
        rst_n = 1; imem_ack = 1; inst_ready = 1;
        #1;
        chk("lit_rel_req", {31'b0, imem_req}, 32'h1);
        chk("lit_rel_addr", imem_addr, 32'h100);
        cyc(); chk("lit_seq0", inst_pc, 32'h100);
        cyc(); chk("lit_seq1", inst_pc, 32'h101);
        cyc(); chk("lit_seq2", inst_pc, 32'h102);
        inst_ready = 0;
        cyc(); chk("lit_full_req", {31'b0, imem_req}, 32'h0); chk("lit_full_pc", inst_pc, 32'h102);
        cyc(); chk("lit_hold_req", {31'b0, imem_req}, 32'h0); chk("lit_hold_pc", inst_pc, 32'h102);
        inst_ready = 1;
        cyc(); chk("lit_resume_req", {31'b0, imem_req}, 32'h1); chk("lit_resume_pc", inst_pc, 32'h103);
        chk("lit_resume_addr", imem_addr, 32'h104);
        cyc(); chk("lit_next_pc", inst_pc, 32'h104);
        imem_ack = 0; npc = 32'h40; npc_load = 1;
        cyc(); chk("lit_drain_valid", {31'b0, inst_valid}, 32'h0); chk("lit_drain_addr", imem_addr, 32'h105);
        npc_load = 0;
        cyc(); chk("lit_drain_addr1", imem_addr, 32'h105);
        cyc(); chk("lit_drain_addr2", imem_addr, 32'h105);
        imem_ack = 1;
        cyc(); chk("lit_drain_disc", {31'b0, inst_valid}, 32'h0); chk("lit_drain_new", imem_addr, 32'h40);
        cyc(); chk("lit_redir_pc", inst_pc, 32'h40);
        npc = 32'h80; npc_load = 1;
        cyc(); chk("lit_ack_redir_addr", imem_addr, 32'h80); chk("lit_flush_pop", {31'b0, inst_valid}, 32'h0);
        npc_load = 0;
        cyc(); chk("lit_ack_redir_pc", inst_pc, 32'h80);
        npc = 32'hFFFF_FFFF; npc_load = 1;
        cyc(); chk("lit_wrap_addr", imem_addr, 32'hFFFF_FFFF);
        npc_load = 0;
        cyc(); chk("lit_wrap_pc0", inst_pc, 32'hFFFF_FFFF);
        cyc(); chk("lit_wrap_pc1", inst_pc, 32'h0);
        imem_ack = 0; npc = 32'h5; npc_load = 1;
        cyc(); chk("lit_d2_addr", imem_addr, 32'h1);
        npc = 32'h7;
        cyc(); chk("lit_d2_stay", imem_addr, 32'h1); chk("lit_d2_req", {31'b0, imem_req}, 32'h1);
        npc_load = 0; rst_n = 0;
        #1;
        chk("lit_mid_rst_req", {31'b0, imem_req}, 32'h0);
        chk("lit_mid_rst_valid", {31'b0, inst_valid}, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("lit_perf_rst", perf_bubble, 32'h0);
`endif
        cyc();
        rst_n = 1;
        #1;
        chk("lit_mid_rel_addr", imem_addr, RPC);
        chk("lit_mid_rel_req", {31'b0, imem_req}, 32'h1);
        for (int i = 0; i < 4000; i++) begin
            cyc();
            rst_n      = $urandom_range(0, 299) != 0;
            imem_ack   = $urandom_range(0, 9) < 6;
            inst_ready = $urandom_range(0, 9) < 6;
            npc_load   = $urandom_range(0, 11) == 0;
            npc        = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                   : 32'($urandom_range(0, 255));
        end
        rst_n = 1; npc_load = 0;
        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
